// File: rtl/or1k_spr_initiator.sv
// SPR bus initiator: issues single or burst SPR reads/writes and returns one
// response beat per access, with a per-access timeout for missing acks.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_*                  command channel (valid/ready), we/addr/dat/len
//   rsp_*                  response channel (valid/ready), dat/err/last
//   spr_access_o/we/re     SPR strobes; spr_addr_o/spr_dat_o address/data
//   spr_bus_ack_i/dat_i    responder acknowledge and read data
module or1k_spr_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int BURST_MAX      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_len_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_last_o,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic        spr_re_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] BMAX     = 4'(BURST_MAX);

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_q, beat_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_last_q, rsp_last_d;
  logic        access_q, access_d;
  logic        spr_we_q, spr_we_d;
  logic        spr_re_q, spr_re_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] spr_dat_q, spr_dat_d;

  logic [3:0]  len_clamp;

  // Zero-length means one beat; oversize bursts saturate.
  always_comb begin
    len_clamp = req_len_i;
    if (req_len_i == 4'd0) begin
      len_clamp = 4'd1;
    end else if (req_len_i > BMAX) begin
      len_clamp = BMAX;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    base_d      = base_q;
    len_d       = len_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;
    access_d    = access_q;
    spr_we_d    = spr_we_q;
    spr_re_d    = spr_re_q;
    addr_d      = addr_q;
    spr_dat_d   = spr_dat_q;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i) begin
          we_d        = req_we_i;
          base_d      = req_addr_i;
          len_d       = len_clamp;
          beat_d      = 4'd0;
          tmo_d       = 8'd0;
          req_ready_d = 1'b0;
          access_d    = 1'b1;
          spr_we_d    = req_we_i;
          spr_re_d    = ~req_we_i;
          addr_d      = req_addr_i;
          spr_dat_d   = req_dat_i;
          state_d     = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // An ack on the final waiting cycle wins over the timeout.
        if (spr_bus_ack_i) begin
          rsp_dat_d   = we_q ? 32'd0 : spr_dat_i;
          rsp_err_d   = 1'b0;
          rsp_last_d  = (beat_q == len_q - 4'd1);
          rsp_valid_d = 1'b1;
          access_d    = 1'b0;
          spr_we_d    = 1'b0;
          spr_re_d    = 1'b0;
          state_d     = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_dat_d   = 32'd0;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_valid_d = 1'b1;
          access_d    = 1'b0;
          spr_we_d    = 1'b0;
          spr_re_d    = 1'b0;
          state_d     = S_RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q || rsp_err_q) begin
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            beat_d   = beat_q + 4'd1;
            tmo_d    = 8'd0;
            access_d = 1'b1;
            spr_we_d = we_q;
            spr_re_d = ~we_q;
            addr_d   = base_q + 16'(beat_d);
            state_d  = S_ACCESS;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      base_q      <= 16'd0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      tmo_q       <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      access_q    <= 1'b0;
      spr_we_q    <= 1'b0;
      spr_re_q    <= 1'b0;
      addr_q      <= 16'd0;
      spr_dat_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      base_q      <= base_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
      access_q    <= access_d;
      spr_we_q    <= spr_we_d;
      spr_re_q    <= spr_re_d;
      addr_q      <= addr_d;
      spr_dat_q   <= spr_dat_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_last_o   = rsp_last_q;
  assign spr_access_o = access_q;
  assign spr_we_o     = spr_we_q;
  assign spr_re_o     = spr_re_q;
  assign spr_addr_o   = addr_q;
  assign spr_dat_o    = spr_dat_q;

endmodule

// File: tb/tb_or1k_spr_initiator.sv
// Directed self-checking bench for or1k_spr_initiator.
// Responder model acks after a programmable number of wait cycles.
module tb_or1k_spr_initiator;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready_o;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_dat;
  logic [3:0]  req_len;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_last_o;
  logic        spr_access_o;
  logic        spr_we_o;
  logic        spr_re_o;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_dat_o;
  logic        spr_bus_ack;
  logic [31:0] spr_rdat;

  int errors;
  int checks;

  int unsigned ack_delay;
  int unsigned wait_cnt;
  bit          use_fixed;
  logic [31:0] fixed_dat;

  logic [15:0] acc_addr [16];
  logic        acc_we   [16];
  logic        acc_re   [16];
  logic [31:0] acc_dat  [16];
  logic [31:0] r_dat    [16];
  logic        r_err    [16];
  logic        r_last   [16];
  int n_acc;
  int n_rsp;
  int acc_cycles;
  int stall_cnt;
  int stall_bad;

  or1k_spr_initiator #(
    .TIMEOUT_CYCLES(16),
    .BURST_MAX(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we),
    .req_addr_i(req_addr),
    .req_dat_i(req_dat),
    .req_len_i(req_len),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o),
    .rsp_last_o(rsp_last_o),
    .spr_access_o(spr_access_o),
    .spr_we_o(spr_we_o),
    .spr_re_o(spr_re_o),
    .spr_addr_o(spr_addr_o),
    .spr_dat_o(spr_dat_o),
    .spr_bus_ack_i(spr_bus_ack),
    .spr_dat_i(spr_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign spr_bus_ack = spr_access_o && (wait_cnt >= ack_delay);
  assign spr_rdat    = use_fixed ? fixed_dat : {16'hC0DE, spr_addr_o};

  always @(posedge clk) begin
    if (spr_access_o && !spr_bus_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic issue(input logic we, input logic [15:0] addr,
                       input logic [31:0] dat, input logic [3:0] len);
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_dat   = dat;
    req_len   = len;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect(input int max_cyc, input int stall_beat,
                         input int stall_len, output bit done);
    logic [31:0] held;
    bit prev;
    held = '0;
    prev = 1'b0;
    done = 1'b0;
    n_acc = 0;
    n_rsp = 0;
    acc_cycles = 0;
    stall_cnt = 0;
    stall_bad = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      if (spr_access_o) begin
        acc_cycles++;
        if (!prev && n_acc < 16) begin
          acc_addr[n_acc] = spr_addr_o;
          acc_we[n_acc]   = spr_we_o;
          acc_re[n_acc]   = spr_re_o;
          acc_dat[n_acc]  = spr_dat_o;
          n_acc++;
        end
      end
      prev = spr_access_o;
      rsp_ready = 1'b1;
      if (rsp_valid_o && n_rsp == stall_beat && stall_cnt < stall_len) begin
        if (stall_cnt == 0) held = rsp_dat_o;
        else if (rsp_dat_o !== held) stall_bad++;
        if (spr_access_o) stall_bad++;
        rsp_ready = 1'b0;
        stall_cnt++;
      end else if (rsp_valid_o && n_rsp < 16) begin
        r_dat[n_rsp]  = rsp_dat_o;
        r_err[n_rsp]  = rsp_err_o;
        r_last[n_rsp] = rsp_last_o;
        n_rsp++;
        if (rsp_last_o || rsp_err_o) done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_last_o,
         spr_access_o, spr_we_o, spr_re_o} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctl got=%b want=1000000",
               {req_ready_o, rsp_valid_o, rsp_err_o, rsp_last_o,
                spr_access_o, spr_we_o, spr_re_o});
    end
    checks++;
    if (spr_addr_o !== 16'd0 || spr_dat_o !== 32'd0 || rsp_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_data addr=%h sdat=%h rdat=%h want 0",
               spr_addr_o, spr_dat_o, rsp_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    use_fixed = 1'b1;
    fixed_dat = 32'hDEADBEEF;
    ack_delay = 0;
    issue(1'b0, 16'h3808, 32'h0, 4'd1);
    @(negedge clk);
    checks++;
    if (spr_access_o !== 1'b1 || spr_re_o !== 1'b1 || spr_we_o !== 1'b0 ||
        spr_addr_o !== 16'h3808 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL single_c1 acc=%b re=%b we=%b addr=%h rdy=%b want 1 1 0 3808 0",
               spr_access_o, spr_re_o, spr_we_o, spr_addr_o, req_ready_o);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'hDEADBEEF ||
        rsp_last_o !== 1'b1 || rsp_err_o !== 1'b0 || spr_access_o !== 1'b0) begin
      errors++;
      $display("FAIL single_c2 v=%b dat=%h last=%b err=%b acc=%b want 1 DEADBEEF 1 0 0",
               rsp_valid_o, rsp_dat_o, rsp_last_o, rsp_err_o, spr_access_o);
    end
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle rdy=%b v=%b want 1 0", req_ready_o, rsp_valid_o);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_burst_write;
    bit done;
    int bad;
    ack_delay = 0;
    issue(1'b1, 16'h3800, 32'h0, 4'd8);
    collect(200, -1, 0, done);
    checks++;
    if (!done || n_acc != 8 || n_rsp != 8) begin
      errors++;
      $display("FAIL burst_wr_count done=%0b acc=%0d rsp=%0d want 1 8 8",
               done, n_acc, n_rsp);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (acc_addr[i] !== 16'h3800 + 16'(i) || acc_we[i] !== 1'b1 ||
          acc_re[i] !== 1'b0 || acc_dat[i] !== 32'd0) bad++;
      if (r_dat[i] !== 32'd0 || r_err[i] !== 1'b0 ||
          r_last[i] !== (i == 7)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL burst_wr_beats bad=%0d want 0", bad);
    end
  endtask

  task automatic test_backpressure;
    bit done;
    ack_delay = 0;
    issue(1'b0, 16'h3810, 32'h0, 4'd3);
    collect(200, 1, 5, done);
    checks++;
    if (!done || n_rsp != 3 || n_acc != 3 || stall_cnt != 5 || stall_bad != 0) begin
      errors++;
      $display("FAIL backpressure done=%0b rsp=%0d acc=%0d stall=%0d bad=%0d want 1 3 3 5 0",
               done, n_rsp, n_acc, stall_cnt, stall_bad);
    end
    checks++;
    if (r_dat[0] !== 32'hC0DE3810 || r_dat[1] !== 32'hC0DE3811 ||
        r_dat[2] !== 32'hC0DE3812 || r_last[2] !== 1'b1 || r_last[1] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_dat got=%h %h %h last=%b%b want C0DE3810..12 last=01",
               r_dat[0], r_dat[1], r_dat[2], r_last[1], r_last[2]);
    end
  endtask

  task automatic test_timeout;
    bit done;
    ack_delay = 1000;
    issue(1'b0, 16'h3820, 32'h0, 4'd4);
    collect(200, -1, 0, done);
    checks++;
    if (!done || acc_cycles != 16 || n_acc != 1 || n_rsp != 1) begin
      errors++;
      $display("FAIL timeout_len done=%0b cyc=%0d acc=%0d rsp=%0d want 1 16 1 1",
               done, acc_cycles, n_acc, n_rsp);
    end
    checks++;
    if (r_err[0] !== 1'b1 || r_last[0] !== 1'b1 || r_dat[0] !== 32'd0) begin
      errors++;
      $display("FAIL timeout_rsp err=%b last=%b dat=%h want 1 1 0",
               r_err[0], r_last[0], r_dat[0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (spr_access_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle acc=%b rdy=%b want 0 1", spr_access_o, req_ready_o);
    end
  endtask

  task automatic test_boundaries;
    bit done;
    ack_delay = 0;
    issue(1'b0, 16'h1000, 32'h0, 4'd0);
    collect(100, -1, 0, done);
    checks++;
    if (!done || n_acc != 1 || n_rsp != 1 || r_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL len0 acc=%0d rsp=%0d last=%b want 1 1 1", n_acc, n_rsp, r_last[0]);
    end
    issue(1'b1, 16'h1100, 32'h12345678, 4'd15);
    collect(200, -1, 0, done);
    checks++;
    if (!done || n_acc != 8 || n_rsp != 8 || acc_addr[7] !== 16'h1107 ||
        acc_dat[3] !== 32'h12345678 || r_last[7] !== 1'b1) begin
      errors++;
      $display("FAIL len15 acc=%0d rsp=%0d a7=%h d3=%h want 8 8 1107 12345678",
               n_acc, n_rsp, acc_addr[7], acc_dat[3]);
    end
    issue(1'b0, 16'hFFFF, 32'h0, 4'd2);
    collect(100, -1, 0, done);
    checks++;
    if (!done || n_acc != 2 || acc_addr[0] !== 16'hFFFF || acc_addr[1] !== 16'h0000 ||
        r_dat[1] !== 32'hC0DE0000) begin
      errors++;
      $display("FAIL addr_wrap acc=%0d a0=%h a1=%h d1=%h want 2 FFFF 0000 C0DE0000",
               n_acc, acc_addr[0], acc_addr[1], r_dat[1]);
    end
    ack_delay = 15;
    issue(1'b0, 16'h2000, 32'h0, 4'd1);
    collect(100, -1, 0, done);
    checks++;
    if (!done || acc_cycles != 16 || r_err[0] !== 1'b0 || r_dat[0] !== 32'hC0DE2000) begin
      errors++;
      $display("FAIL late_ack cyc=%0d err=%b dat=%h want 16 0 C0DE2000",
               acc_cycles, r_err[0], r_dat[0]);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_burst;
    bit done;
    bit found;
    ack_delay = 2;
    found = 1'b0;
    issue(1'b0, 16'h3800, 32'h0, 4'd4);
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      if (spr_access_o && spr_addr_o == 16'h3802) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach beat2 access not seen");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_last_o,
         spr_access_o, spr_we_o, spr_re_o} !== 7'b1000000 ||
        spr_addr_o !== 16'd0 || rsp_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset ctl=%b addr=%h rdat=%h want 1000000 0 0",
               {req_ready_o, rsp_valid_o, rsp_err_o, rsp_last_o,
                spr_access_o, spr_we_o, spr_re_o}, spr_addr_o, rsp_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    issue(1'b0, 16'h0123, 32'h0, 4'd1);
    collect(100, -1, 0, done);
    checks++;
    if (!done || n_acc != 1 || acc_addr[0] !== 16'h0123 ||
        r_dat[0] !== 32'hC0DE0123 || r_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL after_reset acc=%0d a0=%h d0=%h want 1 0123 C0DE0123",
               n_acc, acc_addr[0], r_dat[0]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_dat = '0;
    req_len = '0;
    rsp_ready = 1'b1;
    ack_delay = 0;
    use_fixed = 1'b0;
    fixed_dat = '0;
    test_reset();
    test_single_read();
    test_burst_write();
    test_backpressure();
    test_timeout();
    test_boundaries();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
